el2_dccm_arb: RTL and testbench



---
 rtl/el2_dccm_arb_if.sv | 45 ++++
 rtl/el2_dccm_arb.sv | 148 ++++++++++++++
 tb/tb_el2_dccm_arb.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/el2_dccm_arb_if.sv
// Request, response and SRAM-side signals of the DCCM arbiter.
// slave = arbiter side, master = requesters/SRAM side.
interface el2_dccm_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic                  lsu_wr;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [DATA_W-1:0]     lsu_wdata;
    logic                  lsu_rvalid;
    logic [DATA_W-1:0]     lsu_rdata;
    logic                  dma_valid;
    logic                  dma_ready;
    logic                  dma_wr;
    logic [ADDR_W-1:0]     dma_addr;
    logic [DATA_W-1:0]     dma_wdata;
    logic [DATA_W/8-1:0]   dma_wbe;
    logic                  dma_rvalid;
    logic [DATA_W-1:0]     dma_rdata;
    logic                  dma_wr_done;
    logic                  dccm_rden;
    logic                  dccm_wren;
    logic [ADDR_W-1:0]     dccm_addr;
    logic [DATA_W-1:0]     dccm_wr_data;
    logic [DATA_W-1:0]     dccm_rd_data;
    logic                  busy;

    modport slave (
        input  lsu_valid, lsu_wr, lsu_addr, lsu_wdata,
               dma_valid, dma_wr, dma_addr, dma_wdata, dma_wbe, dccm_rd_data,
        output lsu_ready, lsu_rvalid, lsu_rdata,
               dma_ready, dma_rvalid, dma_rdata, dma_wr_done,
               dccm_rden, dccm_wren, dccm_addr, dccm_wr_data, busy
    );

    modport master (
        output lsu_valid, lsu_wr, lsu_addr, lsu_wdata,
               dma_valid, dma_wr, dma_addr, dma_wdata, dma_wbe, dccm_rd_data,
        input  lsu_ready, lsu_rvalid, lsu_rdata,
               dma_ready, dma_rvalid, dma_rdata, dma_wr_done,
               dccm_rden, dccm_wren, dccm_addr, dccm_wr_data, busy
    );
endinterface

// File: rtl/el2_dccm_arb.sv
// DCCM port arbiter: LSU has priority over DMA; DMA partial writes run as read-modify-write.
// Define RV_DCCM_ARB_STARVE_EN to force a DMA grant after STALL_MAX refused cycles.

module el2_dccm_arb_byte_merge (
    input  logic       en,
    input  logic [7:0] wdata,
    input  logic [7:0] rdata,
    output logic [7:0] merged
);
    assign merged = en ? wdata : rdata;
endmodule

module el2_dccm_arb #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int STALL_MAX = 8
) (
    input logic           clk,
    input logic           rst_l,
    el2_dccm_arb_if.slave bus
);
    localparam int NB = DATA_W / 8;

    if (DATA_W % 8 != 0 || STALL_MAX < 1 || STALL_MAX > 255) begin : g_param_chk
        $error("el2_dccm_arb: DATA_W must be a multiple of 8 and STALL_MAX in 1..255");
    end

    typedef enum logic {IDLE, RMW_MERGE} state_t;
    state_t state, state_nxt;

    logic              force_dma, rdy_lsu, rdy_dma, lsu_xfer, dma_xfer, dma_full, rmw_start;
    logic              rd_lsu, rd_dma, wr_done;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_wdata, merged;
    logic [NB-1:0]     rmw_wbe;
    logic              rden, wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;

    assign rdy_lsu   = (state == IDLE) & ~force_dma;
    assign rdy_dma   = (state == IDLE) & (force_dma | ~bus.lsu_valid);
    assign lsu_xfer  = bus.lsu_valid & rdy_lsu;
    assign dma_xfer  = bus.dma_valid & rdy_dma;
    assign dma_full  = &bus.dma_wbe;
    assign rmw_start = dma_xfer & bus.dma_wr & ~dma_full;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rmw_start) state_nxt = RMW_MERGE;
            RMW_MERGE: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rden    = 1'b0;
        wren    = 1'b0;
        addr    = '0;
        wr_data = '0;
        case (state)
            IDLE: begin
                if (lsu_xfer) begin
                    rden = ~bus.lsu_wr;
                    wren = bus.lsu_wr;
                    addr = bus.lsu_addr;
                    if (bus.lsu_wr) wr_data = bus.lsu_wdata;
                end else if (dma_xfer) begin
                    // A partial write starts with a read of the target word.
                    rden = ~bus.dma_wr | ~dma_full;
                    wren = bus.dma_wr & dma_full;
                    addr = bus.dma_addr;
                    if (bus.dma_wr & dma_full) wr_data = bus.dma_wdata;
                end
            end
            RMW_MERGE: begin
                wren    = 1'b1;
                addr    = rmw_addr;
                wr_data = merged;
            end
            default: ;
        endcase
    end

`ifdef RV_DCCM_ARB_STARVE_EN
    logic [7:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stall_cnt <= '0;
            force_dma <= 1'b0;
        end else begin
            if (dma_xfer || !bus.dma_valid)               stall_cnt <= '0;
            else if (state == IDLE && stall_cnt != 8'hff) stall_cnt <= stall_cnt + 8'd1;
            if (dma_xfer)                          force_dma <= 1'b0;
            else if (stall_cnt == 8'(STALL_MAX))   force_dma <= 1'b1;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_lsu    <= 1'b0;
            rd_dma    <= 1'b0;
            wr_done   <= 1'b0;
            rmw_addr  <= '0;
            rmw_wdata <= '0;
            rmw_wbe   <= '0;
        end else begin
            rd_lsu  <= lsu_xfer & ~bus.lsu_wr;
            rd_dma  <= dma_xfer & ~bus.dma_wr;
            wr_done <= (dma_xfer & bus.dma_wr & dma_full) | (state == RMW_MERGE);
            if (rmw_start) begin
                rmw_addr  <= bus.dma_addr;
                rmw_wdata <= bus.dma_wdata;
                rmw_wbe   <= bus.dma_wbe;
            end
        end
    end

    el2_dccm_arb_byte_merge u_merge [NB-1:0] (
        .en     (rmw_wbe),
        .wdata  (rmw_wdata),
        .rdata  (bus.dccm_rd_data),
        .merged (merged)
    );

    // Strobes and readys are held low while reset is asserted.
    assign bus.lsu_ready    = rst_l & rdy_lsu;
    assign bus.dma_ready    = rst_l & rdy_dma;
    assign bus.dccm_rden    = rst_l & rden;
    assign bus.dccm_wren    = rst_l & wren;
    assign bus.dccm_addr    = rst_l ? addr : '0;
    assign bus.dccm_wr_data = rst_l ? wr_data : '0;
    assign bus.lsu_rvalid   = rd_lsu;
    assign bus.lsu_rdata    = rd_lsu ? bus.dccm_rd_data : '0;
    assign bus.dma_rvalid   = rd_dma;
    assign bus.dma_rdata    = rd_dma ? bus.dccm_rd_data : '0;
    assign bus.dma_wr_done  = wr_done;
    assign bus.busy         = (state == RMW_MERGE) | rd_lsu | rd_dma;
endmodule

// File: tb/tb_el2_dccm_arb.sv
// Self-checking bench for el2_dccm_arb: directed scenarios plus randomized traffic
// checked against a transaction-level model with its own reference memory.
`timescale 1ns/1ps
module tb_el2_dccm_arb;
    localparam int ADDR_W = 16, DATA_W = 32, STALL_MAX = 8;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    el2_dccm_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    el2_dccm_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst_l(rst_l), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // SRAM model: 1-cycle read latency; pokes preload words while the DUT is idle.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] = poke_val;
        else begin
            if (bus.dccm_rden) rd_q <= mem[bus.dccm_addr[9:2]];
            if (bus.dccm_wren) mem[bus.dccm_addr[9:2]] = bus.dccm_wr_data;
        end
    end
    assign bus.dccm_rd_data = rd_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic idle_in();
        bus.lsu_valid = 0; bus.lsu_wr = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
        bus.dma_valid = 0; bus.dma_wr = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_wbe = '0;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk); poke_idx = 8'(idx); poke_val = val; poke_en = 1'b1;
        @(negedge clk); poke_en = 1'b0;
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] w, input logic [31:0] o,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? w[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic test_reset();
        idle_in(); rst_l = 0;
        @(negedge clk); bus.lsu_valid = 1; bus.dma_valid = 1; bus.dma_wr = 1; bus.dma_wbe = 4'h3; #1;
        n_cmp++; if ({bus.lsu_ready, bus.dma_ready, bus.dccm_rden, bus.dccm_wren} !== 4'b0) begin
            n_err++; $display("FAIL reset_strobes got %b want 0000",
                {bus.lsu_ready, bus.dma_ready, bus.dccm_rden, bus.dccm_wren}); end
        n_cmp++; if ({bus.lsu_rvalid, bus.dma_rvalid, bus.dma_wr_done, bus.busy} !== 4'b0) begin
            n_err++; $display("FAIL reset_status got %b want 0000",
                {bus.lsu_rvalid, bus.dma_rvalid, bus.dma_wr_done, bus.busy}); end
        n_cmp++; if ({bus.dccm_addr, bus.dccm_wr_data} !== 48'h0) begin
            n_err++; $display("FAIL reset_addr_data got %h want 0", {bus.dccm_addr, bus.dccm_wr_data}); end
        n_cmp++; if ({bus.lsu_rdata, bus.dma_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata got %h want 0", {bus.lsu_rdata, bus.dma_rdata}); end
        @(negedge clk); idle_in(); rst_l = 1;
    endtask

    task automatic test_lsu_read();
        poke(4, 32'hDEADBEEF);
        @(negedge clk); bus.lsu_valid = 1; bus.lsu_wr = 0; bus.lsu_addr = 16'h0010; #1;
        n_cmp++; if ({bus.lsu_ready, bus.dccm_rden, bus.dccm_wren} !== 3'b110 || bus.dccm_addr !== 16'h0010) begin
            n_err++; $display("FAIL lsu_rd_issue got rdy/rd/wr=%b addr=%h want 110 0010",
                {bus.lsu_ready, bus.dccm_rden, bus.dccm_wren}, bus.dccm_addr); end
        @(negedge clk); idle_in(); #1;
        n_cmp++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL lsu_rd_data got v=%b d=%h want 1 deadbeef", bus.lsu_rvalid, bus.lsu_rdata); end
        n_cmp++; if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL lsu_rd_other got dv=%b dd=%h busy=%b want 0 0 1",
                bus.dma_rvalid, bus.dma_rdata, bus.busy); end
        @(negedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.lsu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL lsu_rd_done got busy=%b rv=%b want 0 0", bus.busy, bus.lsu_rvalid); end
    endtask

    task automatic test_arb_both();
        poke(1, 32'h01010101);
        poke(2, 32'h02020202);
        @(negedge clk); bus.lsu_valid = 1; bus.lsu_addr = 16'h0004;
        bus.dma_valid = 1; bus.dma_wr = 0; bus.dma_addr = 16'h0008; #1;
        n_cmp++; if ({bus.lsu_ready, bus.dma_ready} !== 2'b10 || bus.dccm_addr !== 16'h0004) begin
            n_err++; $display("FAIL arb_lsu_wins got rdy=%b addr=%h want 10 0004",
                {bus.lsu_ready, bus.dma_ready}, bus.dccm_addr); end
        @(negedge clk); bus.lsu_valid = 0; #1;
        n_cmp++; if (bus.dma_ready !== 1'b1 || bus.dccm_rden !== 1'b1 || bus.dccm_addr !== 16'h0008) begin
            n_err++; $display("FAIL arb_dma_next got rdy=%b rd=%b addr=%h want 1 1 0008",
                bus.dma_ready, bus.dccm_rden, bus.dccm_addr); end
        n_cmp++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 32'h01010101) begin
            n_err++; $display("FAIL arb_lsu_data got v=%b d=%h want 1 01010101", bus.lsu_rvalid, bus.lsu_rdata); end
        @(negedge clk); idle_in(); #1;
        n_cmp++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'h02020202 ||
                     bus.lsu_rvalid !== 1'b0 || bus.lsu_rdata !== 32'h0) begin
            n_err++; $display("FAIL arb_dma_data got dv=%b dd=%h lv=%b ld=%h want 1 02020202 0 0",
                bus.dma_rvalid, bus.dma_rdata, bus.lsu_rvalid, bus.lsu_rdata); end
    endtask

    task automatic test_rmw();
        poke(8, 32'hAABBCCDD);
        @(negedge clk); bus.dma_valid = 1; bus.dma_wr = 1; bus.dma_addr = 16'h0020;
        bus.dma_wdata = 32'h11223344; bus.dma_wbe = 4'b0101; #1;
        n_cmp++; if ({bus.dma_ready, bus.dccm_rden, bus.dccm_wren} !== 3'b110 || bus.dccm_addr !== 16'h0020) begin
            n_err++; $display("FAIL rmw_read got rdy/rd/wr=%b addr=%h want 110 0020",
                {bus.dma_ready, bus.dccm_rden, bus.dccm_wren}, bus.dccm_addr); end
        @(negedge clk); idle_in(); bus.lsu_valid = 1; bus.lsu_addr = 16'h0004; #1;
        n_cmp++; if ({bus.lsu_ready, bus.dma_ready, bus.dccm_rden, bus.dccm_wren} !== 4'b0001) begin
            n_err++; $display("FAIL rmw_merge_strobes got %b want 0001",
                {bus.lsu_ready, bus.dma_ready, bus.dccm_rden, bus.dccm_wren}); end
        n_cmp++; if (bus.dccm_wr_data !== 32'hAA22CC44 || bus.dccm_addr !== 16'h0020) begin
            n_err++; $display("FAIL rmw_merge_data got %h @%h want aa22cc44 @0020", bus.dccm_wr_data, bus.dccm_addr); end
        n_cmp++; if (bus.dma_wr_done !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL rmw_merge_status got done=%b busy=%b want 0 1", bus.dma_wr_done, bus.busy); end
        @(negedge clk); #1;
        n_cmp++; if (bus.dma_wr_done !== 1'b1 || bus.dma_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rmw_done got done=%b rv=%b want 1 0", bus.dma_wr_done, bus.dma_rvalid); end
        n_cmp++; if (bus.lsu_ready !== 1'b1 || bus.dccm_rden !== 1'b1 || bus.dccm_addr !== 16'h0004) begin
            n_err++; $display("FAIL rmw_next_accept got rdy=%b rd=%b addr=%h want 1 1 0004",
                bus.lsu_ready, bus.dccm_rden, bus.dccm_addr); end
        @(negedge clk); idle_in(); #1;
        n_cmp++; if (mem[8] !== 32'hAA22CC44) begin
            n_err++; $display("FAIL rmw_mem got %h want aa22cc44", mem[8]); end
    endtask

    task automatic test_full_write();
        @(negedge clk); bus.dma_valid = 1; bus.dma_wr = 1; bus.dma_addr = 16'h0024;
        bus.dma_wdata = 32'hCAFEF00D; bus.dma_wbe = 4'hF; #1;
        n_cmp++; if ({bus.dma_ready, bus.dccm_rden, bus.dccm_wren} !== 3'b101 ||
                     bus.dccm_wr_data !== 32'hCAFEF00D || bus.dccm_addr !== 16'h0024) begin
            n_err++; $display("FAIL full_wr_issue got rdy/rd/wr=%b d=%h a=%h want 101 cafef00d 0024",
                {bus.dma_ready, bus.dccm_rden, bus.dccm_wren}, bus.dccm_wr_data, bus.dccm_addr); end
        @(negedge clk); idle_in(); #1;
        n_cmp++; if (bus.dma_wr_done !== 1'b1 || bus.dccm_wren !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL full_wr_done got done=%b wren=%b busy=%b want 1 0 0",
                bus.dma_wr_done, bus.dccm_wren, bus.busy); end
        n_cmp++; if (mem[9] !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL full_wr_mem got %h want cafef00d", mem[9]); end
    endtask

    task automatic test_reset_mid_rmw();
        poke(10, 32'h55555555);
        @(negedge clk); bus.dma_valid = 1; bus.dma_wr = 1; bus.dma_addr = 16'h0028;
        bus.dma_wdata = 32'hFFFFFFFF; bus.dma_wbe = 4'b0011;
        @(negedge clk); idle_in(); rst_l = 0; #1;
        n_cmp++; if ({bus.dccm_wren, bus.dccm_rden, bus.busy, bus.dma_wr_done, bus.lsu_ready, bus.dma_ready} !== 6'b0 ||
                     bus.dccm_addr !== 16'h0 || bus.dccm_wr_data !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_rmw got wr/rd/busy/done/rdy=%b a=%h d=%h want 0",
                {bus.dccm_wren, bus.dccm_rden, bus.busy, bus.dma_wr_done, bus.lsu_ready, bus.dma_ready},
                bus.dccm_addr, bus.dccm_wr_data); end
        @(negedge clk); #1;
        n_cmp++; if (bus.dma_wr_done !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_rmw_done got done=%b rv=%b want 0 0", bus.dma_wr_done, bus.dma_rvalid); end
        @(negedge clk); rst_l = 1; #1;
        n_cmp++; if (mem[10] !== 32'h55555555) begin
            n_err++; $display("FAIL rst_mid_rmw_mem got %h want 55555555", mem[10]); end
        @(negedge clk); bus.lsu_valid = 1; bus.lsu_addr = 16'h0028; #1;
        n_cmp++; if (bus.lsu_ready !== 1'b1 || bus.dccm_rden !== 1'b1) begin
            n_err++; $display("FAIL rst_after_issue got rdy=%b rd=%b want 1 1", bus.lsu_ready, bus.dccm_rden); end
        @(negedge clk); idle_in(); #1;
        n_cmp++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 32'h55555555) begin
            n_err++; $display("FAIL rst_after_data got v=%b d=%h want 1 55555555", bus.lsu_rvalid, bus.lsu_rdata); end
    endtask

    task automatic test_starve();
        int grant = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); bus.lsu_valid = 1; bus.lsu_wr = 0; bus.lsu_addr = 16'h0;
            bus.dma_valid = (grant < 0); bus.dma_wr = 0; bus.dma_addr = 16'h0004; #1;
            if (grant < 0 && bus.dma_valid && bus.dma_ready) begin
                grant = c;
                n_cmp++; if (bus.lsu_ready !== 1'b0) begin
                    n_err++; $display("FAIL starve_lsu_held got %b want 0", bus.lsu_ready); end
            end else if (grant >= 0 && c == grant + 1) begin
                n_cmp++; if (bus.lsu_ready !== 1'b1) begin
                    n_err++; $display("FAIL starve_lsu_resume got %b want 1", bus.lsu_ready); end
            end
        end
`ifdef RV_DCCM_ARB_STARVE_EN
        n_cmp++; if (grant !== STALL_MAX + 1) begin
            n_err++; $display("FAIL starve_grant_cycle got %0d want %0d", grant, STALL_MAX + 1); end
`else
        n_cmp++; if (grant !== -1) begin
            n_err++; $display("FAIL starve_no_grant got %0d want -1", grant); end
`endif
        @(negedge clk); idle_in();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [0:7];
        bit lp = 0, dp = 0, l_wr = 0, d_wr = 0, mrg = 0;
        logic [15:0] l_addr = '0, d_addr = '0, m_addr = '0;
        logic [31:0] l_wd = '0, d_wd = '0, m_wd = '0, l_rd = '0, d_rd = '0, e_wdata;
        logic [3:0] d_be = '0, m_be = '0;
        bit l_rv = 0, d_rv = 0, d_done = 0, forced, lx, dx, full;
        bit e_lr, e_dr, e_rden, e_wren, drained = 0;
        logic [15:0] e_addr;
        int refused = 0;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            poke(64 + i, ref_mem[i]);
        end
        for (int c = 0; c < 600 && !drained; c++) begin
            @(negedge clk);
            if (c < 500 && !lp && $urandom_range(0, 2) != 0) begin
                lp = 1; l_wr = 1'($urandom_range(0, 1));
                l_addr = 16'h0100 + 16'($urandom_range(0, 7) * 4); l_wd = $urandom;
            end
            if (c < 500 && !dp && $urandom_range(0, 2) == 0) begin
                dp = 1; d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'h0100 + 16'($urandom_range(0, 7) * 4); d_wd = $urandom;
                case ($urandom_range(0, 3))
                    0:       d_be = 4'hF;
                    1:       d_be = 4'h0;
                    default: d_be = 4'($urandom);
                endcase
            end
            bus.lsu_valid = lp; bus.lsu_wr = l_wr; bus.lsu_addr = l_addr; bus.lsu_wdata = l_wd;
            bus.dma_valid = dp; bus.dma_wr = d_wr; bus.dma_addr = d_addr; bus.dma_wdata = d_wd; bus.dma_wbe = d_be;
            #1;
`ifdef RV_DCCM_ARB_STARVE_EN
            forced = (refused > STALL_MAX);
`else
            forced = 0;
`endif
            e_lr = !mrg && !forced;
            e_dr = !mrg && (forced || !lp);
            lx = lp && e_lr;
            dx = dp && e_dr;
            full = (d_be == 4'hF);
            e_rden = 0; e_wren = 0; e_addr = '0; e_wdata = '0;
            if (mrg) begin
                e_wren = 1; e_addr = m_addr; e_wdata = merge_bytes(m_wd, ref_mem[(m_addr - 16'h0100) >> 2], m_be);
            end else if (lx) begin
                e_rden = !l_wr; e_wren = l_wr; e_addr = l_addr; e_wdata = l_wd;
            end else if (dx) begin
                e_rden = !d_wr || !full; e_wren = d_wr && full; e_addr = d_addr; e_wdata = d_wd;
            end
            n_cmp++; if ({bus.lsu_ready, bus.dma_ready} !== {e_lr, e_dr}) begin
                n_err++; $display("FAIL rnd_ready c=%0d got %b want %b", c, {bus.lsu_ready, bus.dma_ready}, {e_lr, e_dr}); end
            n_cmp++; if ({bus.dccm_rden, bus.dccm_wren} !== {e_rden, e_wren}) begin
                n_err++; $display("FAIL rnd_strobe c=%0d got %b want %b", c, {bus.dccm_rden, bus.dccm_wren}, {e_rden, e_wren}); end
            if (e_rden || e_wren) begin
                n_cmp++; if (bus.dccm_addr !== e_addr) begin
                    n_err++; $display("FAIL rnd_addr c=%0d got %h want %h", c, bus.dccm_addr, e_addr); end
            end
            if (e_wren) begin
                n_cmp++; if (bus.dccm_wr_data !== e_wdata) begin
                    n_err++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, bus.dccm_wr_data, e_wdata); end
            end
            n_cmp++; if (bus.lsu_rvalid !== l_rv || bus.lsu_rdata !== (l_rv ? l_rd : 32'h0)) begin
                n_err++; $display("FAIL rnd_lsu_rd c=%0d got %b/%h want %b/%h", c, bus.lsu_rvalid, bus.lsu_rdata, l_rv, l_rd); end
            n_cmp++; if (bus.dma_rvalid !== d_rv || bus.dma_rdata !== (d_rv ? d_rd : 32'h0)) begin
                n_err++; $display("FAIL rnd_dma_rd c=%0d got %b/%h want %b/%h", c, bus.dma_rvalid, bus.dma_rdata, d_rv, d_rd); end
            n_cmp++; if (bus.dma_wr_done !== d_done || bus.busy !== (mrg || l_rv || d_rv)) begin
                n_err++; $display("FAIL rnd_status c=%0d got done=%b busy=%b want %b %b",
                    c, bus.dma_wr_done, bus.busy, d_done, (mrg || l_rv || d_rv)); end
            // Advance the model to the next cycle.
            l_rv = lx && !l_wr; l_rd = ref_mem[(l_addr - 16'h0100) >> 2];
            d_rv = dx && !d_wr; d_rd = ref_mem[(d_addr - 16'h0100) >> 2];
            d_done = mrg || (dx && d_wr && full);
            if (mrg) ref_mem[(m_addr - 16'h0100) >> 2] = e_wdata;
            if (lx && l_wr) ref_mem[(l_addr - 16'h0100) >> 2] = l_wd;
            if (dx && d_wr && full) ref_mem[(d_addr - 16'h0100) >> 2] = d_wd;
            mrg = dx && d_wr && !full;
            if (mrg) begin m_addr = d_addr; m_wd = d_wd; m_be = d_be; end
            if (dx || !dp) refused = 0;
            else if (e_lr || !e_dr && !(!e_lr && !e_dr)) refused++;
            if (lx) lp = 0;
            if (dx) dp = 0;
            drained = (c >= 500) && !lp && !dp && !mrg && !l_rv && !d_rv && !d_done;
        end
        n_cmp++; if (!drained) begin
            n_err++; $display("FAIL rnd_drain got pending want drained"); end
        @(negedge clk); idle_in(); #1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (mem[64 + i] !== ref_mem[i]) begin
                n_err++; $display("FAIL rnd_mem[%0d] got %h want %h", i, mem[64 + i], ref_mem[i]); end
        end
    endtask

    initial begin
        idle_in();
        test_reset();
        test_lsu_read();
        test_arb_both();
        test_rmw();
        test_full_write();
        test_reset_mid_rmw();
        test_starve();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
